decode_stage: RTL



---
 rtl/decode_pkg.sv | 64 ++++++
 rtl/decode_comb.sv | 134 +++++++++++++
 rtl/decode_stage.sv | 85 ++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared types for the RV32 decode stage: control bundle, ALU op codes,
// operand/write-back selectors, immediate formats and base opcodes.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Base ops use the 4-bit range with NOP at zero; RV32M ops set bit 4 and
  // carry funct3 in the low bits.
  typedef enum logic [4:0] {
    ALU_NOP  = 5'd0,  ALU_ADD   = 5'd1,  ALU_SUB    = 5'd2,  ALU_AND   = 5'd3,
    ALU_OR   = 5'd4,  ALU_XOR   = 5'd5,  ALU_SLL    = 5'd6,  ALU_SRL   = 5'd7,
    ALU_SRA  = 5'd8,  ALU_LT    = 5'd9,  ALU_LTU    = 5'd10,
    ALU_MUL  = 5'd16, ALU_MULH  = 5'd17, ALU_MULHSU = 5'd18, ALU_MULHU = 5'd19,
    ALU_DIV  = 5'd20, ALU_DIVU  = 5'd21, ALU_REM    = 5'd22, ALU_REMU  = 5'd23
  } alu_op_e;

  // SRCB_PC_IMM: operand a is pc and operand b is imm (AUIPC, JAL target).
  typedef enum logic [1:0] {SRCB_RS2, SRCB_IMM, SRCB_PC_IMM} src_b_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4, WB_IMM} wb_src_e;
  typedef enum logic [2:0] {IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

  typedef struct packed {
    alu_op_e     alu_op;
    src_b_e      alu_src_b;
    logic        rf_we;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        mem_we;
    logic        mem_re;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    wb_src_e     wb_src;
    logic        is_branch;
    logic [2:0]  br_cond;
    logic        is_jal;
    logic        is_jalr;
    logic        illegal;
    logic [31:0] pc;
  } ctrl_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I(+M) decoder: instruction word and pc to a ctrl_t bundle.
module decode_comb
  import decode_pkg::*;
#(
  parameter bit EN_M = 1'b0
) (
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output ctrl_t       ctrl
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  imm_fmt_e   fmt;
  logic       writes;
  logic       legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  always_comb begin
    ctrl   = '0;
    fmt    = IMM_R;
    writes = 1'b0;
    legal  = 1'b1;
    case (opcode)
      OPC_LUI: begin
        fmt = IMM_U; writes = 1'b1; ctrl.wb_src = WB_IMM;
      end
      OPC_AUIPC: begin
        fmt = IMM_U; writes = 1'b1; ctrl.alu_op = ALU_ADD; ctrl.alu_src_b = SRCB_PC_IMM;
      end
      OPC_JAL: begin
        fmt = IMM_J; writes = 1'b1; ctrl.is_jal = 1'b1; ctrl.wb_src = WB_PC4;
        ctrl.alu_op = ALU_ADD; ctrl.alu_src_b = SRCB_PC_IMM;
      end
      OPC_JALR: begin
        fmt = IMM_I; writes = 1'b1; ctrl.is_jalr = 1'b1; ctrl.wb_src = WB_PC4;
        ctrl.alu_op = ALU_ADD; ctrl.alu_src_b = SRCB_IMM; legal = (funct3 == 3'b000);
      end
      OPC_BRANCH: begin
        fmt = IMM_B; ctrl.is_branch = 1'b1; ctrl.br_cond = funct3;
        case (funct3)
          3'b000, 3'b001: ctrl.alu_op = ALU_SUB;
          3'b100, 3'b101: ctrl.alu_op = ALU_LT;
          3'b110, 3'b111: ctrl.alu_op = ALU_LTU;
          default:        legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        fmt = IMM_I; writes = 1'b1; ctrl.mem_re = 1'b1; ctrl.wb_src = WB_MEM;
        ctrl.alu_op = ALU_ADD; ctrl.alu_src_b = SRCB_IMM;
        ctrl.mem_size = funct3[1:0]; ctrl.mem_unsigned = funct3[2];
        legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      OPC_STORE: begin
        fmt = IMM_S; ctrl.mem_we = 1'b1; ctrl.alu_op = ALU_ADD; ctrl.alu_src_b = SRCB_IMM;
        ctrl.mem_size = funct3[1:0]; legal = !funct3[2] && (funct3[1:0] != 2'b11);
      end
      OPC_OP_IMM: begin
        fmt = IMM_I; writes = 1'b1; ctrl.alu_src_b = SRCB_IMM;
        case (funct3)
          3'b000: ctrl.alu_op = ALU_ADD;
          3'b010: ctrl.alu_op = ALU_LT;
          3'b011: ctrl.alu_op = ALU_LTU;
          3'b100: ctrl.alu_op = ALU_XOR;
          3'b110: ctrl.alu_op = ALU_OR;
          3'b111: ctrl.alu_op = ALU_AND;
          3'b001: begin
            ctrl.alu_op = ALU_SLL; legal = (funct7 == 7'h00);
          end
          default: begin
            ctrl.alu_op = funct7[5] ? ALU_SRA : ALU_SRL;
            legal = (funct7 == 7'h00) || (funct7 == 7'h20);
          end
        endcase
      end
      OPC_OP: begin
        writes = 1'b1;
        case (funct7)
          7'h00:
            case (funct3)
              3'b000: ctrl.alu_op = ALU_ADD;
              3'b001: ctrl.alu_op = ALU_SLL;
              3'b010: ctrl.alu_op = ALU_LT;
              3'b011: ctrl.alu_op = ALU_LTU;
              3'b100: ctrl.alu_op = ALU_XOR;
              3'b101: ctrl.alu_op = ALU_SRL;
              3'b110: ctrl.alu_op = ALU_OR;
              default: ctrl.alu_op = ALU_AND;
            endcase
          7'h20:
            case (funct3)
              3'b000:  ctrl.alu_op = ALU_SUB;
              3'b101:  ctrl.alu_op = ALU_SRA;
              default: legal = 1'b0;
            endcase
          7'h01:
            if (EN_M) begin
              case (funct3)
                3'b000: ctrl.alu_op = ALU_MUL;
                3'b001: ctrl.alu_op = ALU_MULH;
                3'b010: ctrl.alu_op = ALU_MULHSU;
                3'b011: ctrl.alu_op = ALU_MULHU;
                3'b100: ctrl.alu_op = ALU_DIV;
                3'b101: ctrl.alu_op = ALU_DIVU;
                3'b110: ctrl.alu_op = ALU_REM;
                default: ctrl.alu_op = ALU_REMU;
              endcase
            end else begin
              legal = 1'b0;
            end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase

    ctrl.imm   = gen_imm(instr, fmt);
    ctrl.rf_we = writes && (instr[11:7] != 5'd0);
    // An illegal bundle keeps only register indices and pc for trap reporting.
    if (!legal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
    end
    ctrl.rd  = instr[11:7];
    ctrl.rs1 = instr[19:15];
    ctrl.rs2 = instr[24:20];
    ctrl.pc  = pc;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready handshake, optional skid entry and flush.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit EN_M = 1'b0,
  parameter bit SKID = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output ctrl_t           out_ctrl
);

  ctrl_t dec;
  logic  in_fire;
  logic  out_fire;

  decode_comb #(.EN_M(EN_M)) u_decode_comb (
    .instr (in_instr),
    .pc    (in_pc),
    .ctrl  (dec)
  );

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  if (SKID) begin : g_skid
    ctrl_t skid_ctrl;
    logic  skid_valid;

    assign in_ready = !skid_valid;

    // NOTE: non-blocking assignments keep every register update on the edge
    // independent of statement order. The bundle registers are reset as well
    // so out_ctrl reads all-zero (ALU_NOP) straight after reset.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_valid  <= 1'b0;
        out_ctrl   <= '0;
        skid_valid <= 1'b0;
        skid_ctrl  <= '0;
      end else if (flush) begin
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
      end else if (out_fire || !out_valid) begin
        // Output register frees up: the skid entry is older than any new input.
        if (skid_valid) begin
          out_ctrl   <= skid_ctrl;
          out_valid  <= 1'b1;
          skid_valid <= 1'b0;
        end else begin
          out_valid <= in_fire;
          if (in_fire) out_ctrl <= dec;
        end
      end else if (in_fire) begin
        skid_ctrl  <= dec;
        skid_valid <= 1'b1;
      end
    end
  end else begin : g_single
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_valid <= 1'b0;
        out_ctrl  <= '0;
      end else if (flush) begin
        out_valid <= 1'b0;
      end else if (in_fire) begin
        out_valid <= 1'b1;
        out_ctrl  <= dec;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
